clock_edge_monitor: RTL

Receive-side companion to the team's toggle clock divider. Samples a slow, asynchronous clock-like signal (typically a divided clock) in the `clk_in` domain and synchronizes it. Produces one-cycle rise/fall strobes for use as clock enables, measures the rise-to-rise period in `clk_in` cycles, and flags a stalled input. Measurements leave through a valid/ready holding register.

---
 rtl/clock_edge_monitor.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/clock_edge_monitor.sv
// Synchronizes a slow asynchronous clock-like input, emits rise/fall strobes, measures rise-to-rise
// period behind a valid/ready holding register and flags stalls; CLOCK_EDGE_MONITOR_DUTY_EN adds high-time.
module clock_edge_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 1000
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic             sig_sync,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             overrun,
    output logic             stalled,
    output logic [CNT_W-1:0] high_time
);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_WAIT_FIRST = 2'd0,
        ST_MEASURE    = 2'd1,
        ST_STALLED    = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   rise_d;
    logic                   fall_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    state_e                 state_q;
    state_e                 state_d;
    logic                   load;
    logic                   xfer;
    logic [CNT_W-1:0]       period_q;
    logic                   valid_q;
    logic                   overrun_q;

    assign sig_sync = sync_q[SYNC_STAGES-1];
    // Edge events are decoded one cycle early so the registered strobes and the report share an edge.
    assign rise_d   = sig_sync & ~prev_q;
    assign fall_d   = ~sig_sync & prev_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sig_sync;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (rise_d) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_FIRST: if (rise_d) state_d = ST_MEASURE;
            ST_MEASURE:    if (!rise_d && (cnt_d == TIMEOUT_C)) state_d = ST_STALLED;
            ST_STALLED:    if (rise_d) state_d = ST_MEASURE;
            default:       state_d = ST_WAIT_FIRST;
        endcase
    end

    // Only a rise that closes an interval started in MEASURE is a trustworthy period.
    always_comb begin
        load    = 1'b0;
        stalled = 1'b0;
        case (state_q)
            ST_MEASURE: load    = rise_d;
            ST_STALLED: stalled = 1'b1;
            default: begin
                load    = 1'b0;
                stalled = 1'b0;
            end
        endcase
    end

    assign xfer = valid_q & period_ready;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            period_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (load) begin
                period_q  <= cnt_q;
                valid_q   <= 1'b1;
                overrun_q <= valid_q & ~period_ready;
            end else if (xfer) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign overrun      = overrun_q;

`ifdef CLOCK_EDGE_MONITOR_DUTY_EN
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] pend_q;
    logic [CNT_W-1:0] high_q;

    // The pending value is the high phase of the period the next report closes.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            pend_q <= '0;
            high_q <= '0;
        end else begin
            if (rise_d) begin
                hcnt_q <= CNT_ONE;
            end else if (sig_sync && (hcnt_q != CNT_MAX)) begin
                hcnt_q <= hcnt_q + CNT_ONE;
            end
            if (fall_d) begin
                pend_q <= hcnt_q;
            end
            if (load) begin
                high_q <= pend_q;
            end
        end
    end

    assign high_time = high_q;
`else
    assign high_time = '0;
`endif

endmodule
